lift_door_ctrl: RTL
===================

LIFT_DOOR_CTRL -- requirements
Module: lift_door_ctrl

Interface
REQ-001 SHALL have parameter MOVE_CYCLES, default 4: clock cycles for the door to travel fully between closed and open (legal range 1..255).
REQ-002 SHALL have parameter OPEN_CYCLES, default 10: dwell cycles at fully open (legal range 1..65535).
REQ-003 SHALL have parameter MAX_REOPEN, default 3: obstruction reversals allowed before nudge closing (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_motion, input, 1 bit: car moving, from the main ALU stage.
REQ-007 SHALL have port i_has_rqst_at_stopped_flr, input, 1 bit: request pending at the floor where the car is stopped.
REQ-008 SHALL have port i_obstruct, input, 1 bit: door-edge sensor blocked.
REQ-009 SHALL have port i_open_btn, input, 1 bit: cabin door-open button, level.
REQ-010 SHALL have port i_close_btn, input, 1 bit: cabin door-close button, level.
REQ-011 SHALL have port o_door_open, output, 1 bit: door not fully closed; fed to the main ALU i_door_open, whose falling edge clears served requests.
REQ-012 SHALL have port o_door_opening, output, 1 bit: high in OPENING.
REQ-013 SHALL have port o_door_closing, output, 1 bit: high in CLOSING.
REQ-014 SHALL have port o_fully_open, output, 1 bit: high in OPEN.
REQ-015 SHALL have port o_buzzer, output, 1 bit: nudge warning.

Function
REQ-016 SHALL implement FSM states CLOSED, OPENING, OPEN, CLOSING; all outputs registered.
REQ-017 SHALL keep door position counter pos, width clog2(MOVE_CYCLES+1): +1 per cycle in OPENING, -1 per cycle in CLOSING, saturating at 0 and MOVE_CYCLES.
REQ-018 SHALL transition CLOSED->OPENING the cycle after sampling ~i_motion & (i_has_rqst_at_stopped_flr | i_open_btn); otherwise remain CLOSED.
REQ-019 SHALL ignore i_has_rqst_at_stopped_flr and i_open_btn while i_motion=1.
REQ-020 SHALL transition OPENING->OPEN when pos reaches MOVE_CYCLES, loading dwell counter with OPEN_CYCLES.
REQ-021 SHALL decrement dwell each cycle in OPEN; i_open_btn=1 reloads dwell to OPEN_CYCLES; i_close_btn=1 without i_open_btn forces dwell to 0; open wins when both are high.
REQ-022 SHALL transition OPEN->CLOSING when dwell reaches 0 and i_obstruct=0; with i_obstruct=1, remain OPEN with dwell held at 0.
REQ-023 SHALL transition CLOSING->OPENING on i_obstruct or i_open_btn, keeping current pos (partial reversal), and increment reopen counter (saturating at MAX_REOPEN).
REQ-024 SHALL transition CLOSING->CLOSED when pos reaches 0 with no reversal that cycle, clearing the reopen counter; reversal wins over close completion in the same cycle.
REQ-025 SHALL drive o_door_open=1 in every state except CLOSED, so one service produces exactly one falling edge.

Reset
REQ-026 SHALL, on reset_n=0, immediately force state CLOSED, pos=0, dwell=0, reopen count=0, all outputs 0, including mid-travel.
REQ-027 SHALL evaluate REQ-018 on the first rising clk edge after reset_n deasserts.

Configuration
REQ-028 SHALL, with macro LIFT_DOOR_NUDGE_EN defined, enter nudge mode in CLOSING once the reopen count equals MAX_REOPEN: i_obstruct and i_open_btn are ignored, o_buzzer=1 throughout that CLOSING, and the door closes to CLOSED.
REQ-029 SHALL, without LIFT_DOOR_NUDGE_EN, always reverse per REQ-023 without limit, with o_buzzer tied 0.

Verification
REQ-030 SHALL verify: defaults, i_has_rqst_at_stopped_flr pulse at cycle 0 -> o_door_open high cycles 1..18, o_fully_open high cycles 5..14, then a single falling edge.
REQ-031 SHALL verify: i_motion=1 with i_has_rqst_at_stopped_flr=1 for 20 cycles -> o_door_open stays 0.
REQ-032 SHALL verify: i_obstruct at 2nd CLOSING cycle (pos=3) -> OPENING next cycle, OPEN after 1 more cycle, dwell restarts at 10.
REQ-033 SHALL verify: i_close_btn in 1st OPEN cycle -> CLOSING next cycle; i_open_btn held 15 cycles in OPEN -> OPEN persists 15+10 cycles.
REQ-034 SHALL verify: LIFT_DOOR_NUDGE_EN, obstruction on 4 successive closings -> 4th closing has o_buzzer=1, ignores i_obstruct, reaches CLOSED; without macro, 4th reverses.
REQ-035 SHALL verify: reset_n low during OPENING pos=2 -> outputs 0 asynchronously, CLOSED after release.

Source files
------------

// File: rtl/lift_door_ctrl.sv
// lift_door_ctrl: lift door FSM (CLOSED/OPENING/OPEN/CLOSING) with travel, dwell and reopen tracking.
// Optional nudge closing after MAX_REOPEN reversals is enabled by defining LIFT_DOOR_NUDGE_EN.
module lift_door_ctrl #(
  parameter int MOVE_CYCLES = 4,
  parameter int OPEN_CYCLES = 10,
  parameter int MAX_REOPEN  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_motion,
  input  logic i_has_rqst_at_stopped_flr,
  input  logic i_obstruct,
  input  logic i_open_btn,
  input  logic i_close_btn,
  output logic o_door_open,
  output logic o_door_opening,
  output logic o_door_closing,
  output logic o_fully_open,
  output logic o_buzzer
);
  localparam int PW = $clog2(MOVE_CYCLES + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(MOVE_CYCLES);
  localparam logic [15:0] DWELL = 16'(OPEN_CYCLES);
  localparam logic [3:0] REOPEN_MAX = 4'(MAX_REOPEN);
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;
  state_t r_state, w_nxt;
  logic [PW-1:0] r_pos, w_pos;
  logic [15:0] r_dwell, w_dwell;
  logic [3:0] r_reopen, w_reopen;
  logic w_nudge, w_rev, w_buzz;
  always_comb begin
    w_nxt = r_state;
    w_pos = r_pos;
    w_dwell = r_dwell;
    w_reopen = r_reopen;
`ifdef LIFT_DOOR_NUDGE_EN
    w_nudge = (r_reopen == REOPEN_MAX);
`else
    w_nudge = 1'b0;
`endif
    w_rev = (i_obstruct | i_open_btn) & ~w_nudge;
    case (r_state)
      CLOSED: w_nxt = (~i_motion & (i_has_rqst_at_stopped_flr | i_open_btn)) ? OPENING : CLOSED;
      OPENING: begin
        w_pos = (r_pos == POS_MAX) ? r_pos : r_pos + 1'b1;
        if (w_pos == POS_MAX) begin
          w_nxt = OPEN;
          w_dwell = DWELL;
        end
      end
      OPEN: begin
        w_dwell = i_open_btn ? DWELL : (i_close_btn || r_dwell == '0) ? '0 : r_dwell - 1'b1;
        w_nxt = (w_dwell == '0 && !i_obstruct) ? CLOSING : OPEN;
      end
      default: begin
        // reversal keeps the current position so the door reopens from where it stopped
        if (w_rev) begin
          w_nxt = OPENING;
          w_reopen = (r_reopen == REOPEN_MAX) ? r_reopen : r_reopen + 1'b1;
        end else begin
          w_pos = (r_pos == '0) ? r_pos : r_pos - 1'b1;
          if (w_pos == '0) begin
            w_nxt = CLOSED;
            w_reopen = '0;
          end
        end
      end
    endcase
`ifdef LIFT_DOOR_NUDGE_EN
    w_buzz = (w_nxt == CLOSING) && (w_reopen == REOPEN_MAX);
`else
    w_buzz = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLOSED;
      r_pos <= '0;
      r_dwell <= '0;
      r_reopen <= '0;
      o_door_open <= 1'b0;
      o_door_opening <= 1'b0;
      o_door_closing <= 1'b0;
      o_fully_open <= 1'b0;
      o_buzzer <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_pos <= w_pos;
      r_dwell <= w_dwell;
      r_reopen <= w_reopen;
      o_door_open <= (w_nxt != CLOSED);
      o_door_opening <= (w_nxt == OPENING);
      o_door_closing <= (w_nxt == CLOSING);
      o_fully_open <= (w_nxt == OPEN);
      o_buzzer <= w_buzz;
    end
  end
endmodule
